uart_rx_module: RTL and testbench

UART_RX_MODULE -- requirements
Module: uart_rx_module

---
 rtl/biosig_pkg.sv | 29 ++
 rtl/uart_rx_module.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_module.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/biosig_pkg.sv
// Shared UART definitions for the biosignal front end: default line rates,
// TX/RX state encodings and the clocks-per-bit helper.
package biosig_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;
    localparam int unsigned DEFAULT_BAUD   = 115_200;
    localparam int unsigned UART_DATA_W    = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_rx_state_t;

    // Integer clock cycles per serial bit; truncates like the TX side does.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver: 2-FF input synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready output holding register with overrun detection.
module uart_rx_module
    import biosig_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD   = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF_M1      = (CLKS_PER_BIT >= 2) ? (CLKS_PER_BIT / 2) - 1 : 0;
    localparam int unsigned FULL_M1      = (CLKS_PER_BIT >= 1) ? CLKS_PER_BIT - 1 : 0;

    localparam logic [BAUD_W-1:0] HALF_TC = BAUD_W'(HALF_M1);
    localparam logic [BAUD_W-1:0] FULL_TC = BAUD_W'(FULL_M1);

    logic                r_rx_meta;
    logic                r_rx_s;
    uart_rx_state_t      r_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_err_wait;

    uart_rx_state_t      w_state_next;
    logic [BAUD_W-1:0]   w_baud_next;
    logic [2:0]          w_bit_idx_next;
    logic [7:0]          w_shift_next;
    logic                w_err_wait_next;
    logic                w_byte_done;
    logic                w_stop_bad;

    // Input synchronizer; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx_i;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RX_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_err_wait <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit_idx  <= w_bit_idx_next;
            r_shift    <= w_shift_next;
            r_err_wait <= w_err_wait_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_baud_next     = r_baud;
        w_bit_idx_next  = r_bit_idx;
        w_shift_next    = r_shift;
        w_err_wait_next = r_err_wait;
        w_byte_done     = 1'b0;
        w_stop_bad      = 1'b0;

        case (r_state)
            RX_IDLE: begin
                w_baud_next     = '0;
                w_bit_idx_next  = '0;
                w_err_wait_next = 1'b0;
                if (!r_rx_s) begin
                    w_state_next = RX_START;
                end
            end

            // Recheck the line at mid start bit to reject short glitches.
            RX_START: begin
                if (r_baud == HALF_TC) begin
                    w_baud_next  = '0;
                    w_state_next = r_rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end

            RX_DATA: begin
                if (r_baud == FULL_TC) begin
                    w_baud_next    = '0;
                    w_shift_next   = {r_rx_s, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = RX_STOP;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end

            // A low stop bit parks here until the line returns high.
            RX_STOP: begin
                if (r_err_wait) begin
                    if (r_rx_s) begin
                        w_err_wait_next = 1'b0;
                        w_state_next    = RX_IDLE;
                    end
                end else if (r_baud == FULL_TC) begin
                    w_baud_next = '0;
                    if (r_rx_s) begin
                        w_byte_done  = 1'b1;
                        w_state_next = RX_IDLE;
                    end else begin
                        w_stop_bad      = 1'b1;
                        w_err_wait_next = 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end

            default: begin
                w_state_next = RX_IDLE;
            end
        endcase
    end

    // Output holding register: a completing byte may replace the pending one
    // only when that pending byte is being accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o      <= 8'h00;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            frame_err_o <= w_stop_bad;
            overrun_o   <= 1'b0;
            busy_o      <= (w_state_next != RX_IDLE);
            if (w_byte_done) begin
                if (!valid_o || ready_i) begin
                    data_o  <= r_shift;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_module.sv
// Self-checking bench for uart_rx_module: drives 8N1 frames bit by bit and
// scores accepted bytes and error pulses against per-scenario expectations.
module tb_uart_rx_module;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned BAUD   = 115_200;
    localparam int unsigned CPB    = CLK_HZ / BAUD;
    localparam int unsigned HALF   = CPB / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    int err_cnt = 0;
    int ovr_cnt = 0;
    int vcyc    = 0;

    uart_rx_module #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx_i  (uart_rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    always #10 clk = ~clk;

    // Monitor: record handshaken bytes and pulse counts away from the active edge.
    always @(negedge clk) begin
        if (valid_o && ready_i) rx_q.push_back(data_o);
        if (frame_err_o) err_cnt = err_cnt + 1;
        if (overrun_o) ovr_cnt = ovr_cnt + 1;
        if (valid_o) vcyc = vcyc + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic lvl);
        uart_rx_i = lvl;
        tick(int'(CPB));
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_lvl);
        uart_rx_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        uart_rx_i = 1'b1;
        ready_i = 1'b0;
        tick(3);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", data_o); end
        checks++; if (frame_err_o !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b expected 0", frame_err_o); end
        checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b expected 0", overrun_o); end
        rst = 1'b0;
        tick(5);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        int base = rx_q.size();
        int e0 = err_cnt;
        int o0 = ovr_cnt;
        int v0 = vcyc;
        ready_i = 1'b1;
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        tick(10);
        checks++; if (rx_q.size() - base != 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", rx_q.size() - base); end
        else begin
            checks++; if (rx_q[base] !== 8'h55) begin failures++; $display("FAIL b2b_byte0: got %h expected 55", rx_q[base]); end
            checks++; if (rx_q[base+1] !== 8'hA3) begin failures++; $display("FAIL b2b_byte1: got %h expected a3", rx_q[base+1]); end
        end
        checks++; if (vcyc - v0 != 2) begin failures++; $display("FAIL b2b_valid_cycles: got %0d expected 2", vcyc - v0); end
        checks++; if (err_cnt - e0 != 0 || ovr_cnt - o0 != 0) begin failures++; $display("FAIL b2b_errors: got ferr=%0d ovr=%0d expected 0/0", err_cnt - e0, ovr_cnt - o0); end
    endtask

    task automatic test_glitch();
        int base = rx_q.size();
        int e0 = err_cnt;
        int v0 = vcyc;
        uart_rx_i = 1'b0;
        tick(50);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL glitch_busy_mid: got %b expected 1", busy_o); end
        tick(50);
        uart_rx_i = 1'b1;
        tick(300);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL glitch_idle: got busy=%b expected 0", busy_o); end
        checks++; if (vcyc - v0 != 0 || rx_q.size() != base) begin failures++; $display("FAIL glitch_valid: got %0d valid cycles expected 0", vcyc - v0); end
        checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL glitch_ferr: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_frame_error();
        int base = rx_q.size();
        int e0 = err_cnt;
        int v0 = vcyc;
        ready_i = 1'b1;
        send_frame(8'h3C, 1'b0);
        tick(10);
        checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL ferr_pulse: got %0d cycles expected 1", err_cnt - e0); end
        checks++; if (vcyc - v0 != 0) begin failures++; $display("FAIL ferr_valid: got %0d valid cycles expected 0", vcyc - v0); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL ferr_idle: got busy=%b expected 0", busy_o); end
        tick(int'(CPB));
        send_frame(8'h81, 1'b1);
        tick(10);
        checks++; if (rx_q.size() - base != 1) begin failures++; $display("FAIL ferr_next_count: got %0d expected 1", rx_q.size() - base); end
        else begin
            checks++; if (rx_q[base] !== 8'h81) begin failures++; $display("FAIL ferr_next_byte: got %h expected 81", rx_q[base]); end
        end
        checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL ferr_total: got %0d expected 1", err_cnt - e0); end
    endtask

    task automatic test_overrun();
        int base = rx_q.size();
        int o0 = ovr_cnt;
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(10);
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL ovr_valid_held: got %b expected 1", valid_o); end
        checks++; if (data_o !== 8'h11) begin failures++; $display("FAIL ovr_data_held: got %h expected 11", data_o); end
        checks++; if (ovr_cnt - o0 != 1) begin failures++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ovr_cnt - o0); end
        ready_i = 1'b1;
        tick(1);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL ovr_valid_clear: got %b expected 0", valid_o); end
        checks++; if (rx_q.size() - base != 1 || rx_q[rx_q.size()-1] !== 8'h11) begin failures++; $display("FAIL ovr_accepted: got %0d bytes expected one 11", rx_q.size() - base); end
    endtask

    task automatic test_simultaneous();
        int base = rx_q.size();
        int o0 = ovr_cnt;
        logic [7:0] b2 = 8'h7E;
        ready_i = 1'b0;
        send_frame(8'hC3, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b2[i]);
        uart_rx_i = 1'b1;
        // Stop sample lands HALF+3 edges into the stop bit (2 sync + 1 detect).
        tick(int'(HALF) + 2);
        ready_i = 1'b1;
        tick(1);
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL sim_valid: got %b expected 1", valid_o); end
        checks++; if (data_o !== 8'h7E) begin failures++; $display("FAIL sim_data: got %h expected 7e", data_o); end
        checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL sim_ovr: got %b expected 0", overrun_o); end
        tick(1);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL sim_clear: got %b expected 0", valid_o); end
        tick(int'(CPB - HALF) - 4);
        checks++; if (rx_q.size() - base != 2) begin failures++; $display("FAIL sim_count: got %0d expected 2", rx_q.size() - base); end
        else begin
            checks++; if (rx_q[base] !== 8'hC3 || rx_q[base+1] !== 8'h7E) begin failures++; $display("FAIL sim_bytes: got %h %h expected c3 7e", rx_q[base], rx_q[base+1]); end
        end
        checks++; if (ovr_cnt - o0 != 0) begin failures++; $display("FAIL sim_ovr_total: got %0d expected 0", ovr_cnt - o0); end
    endtask

    task automatic test_reset_midframe();
        int base = rx_q.size();
        int e0 = err_cnt;
        int o0 = ovr_cnt;
        logic [7:0] b = 8'hF0;
        ready_i = 1'b1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        uart_rx_i = b[4];
        tick(int'(HALF));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (valid_o !== 1'b0 || data_o !== 8'h00) begin failures++; $display("FAIL midrst_out: got valid=%b data=%h expected 0/00", valid_o, data_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
        checks++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin failures++; $display("FAIL midrst_pulses: got ferr=%b ovr=%b expected 0/0", frame_err_o, overrun_o); end
        tick(int'(CPB - HALF) - 1);
        for (int i = 5; i < 8; i++) drive_bit(b[i]);
        drive_bit(1'b1);
        tick(10);
        checks++; if (rx_q.size() != base || err_cnt != e0 || ovr_cnt != o0) begin failures++; $display("FAIL midrst_quiet: got bytes=%0d ferr=%0d ovr=%0d expected 0/0/0", rx_q.size() - base, err_cnt - e0, ovr_cnt - o0); end
        send_frame(8'h0F, 1'b1);
        tick(10);
        checks++; if (rx_q.size() - base != 1) begin failures++; $display("FAIL midrst_next_count: got %0d expected 1", rx_q.size() - base); end
        else begin
            checks++; if (rx_q[base] !== 8'h0F) begin failures++; $display("FAIL midrst_next_byte: got %h expected 0f", rx_q[base]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int base = rx_q.size();
        int e0 = err_cnt;
        int o0 = ovr_cnt;
        ready_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            logic [7:0] b = 8'($urandom);
            int gap = int'($urandom_range(0, 40));
            send_frame(b, 1'b1);
            exp_q.push_back(b);
            tick(gap);
        end
        tick(10);
        checks++; if (rx_q.size() - base != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d expected %0d", rx_q.size() - base, exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (rx_q[base+i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d: got %h expected %h", i, rx_q[base+i], exp_q[i]); end
            end
        end
        checks++; if (err_cnt != e0 || ovr_cnt != o0) begin failures++; $display("FAIL rand_errors: got ferr=%0d ovr=%0d expected 0/0", err_cnt - e0, ovr_cnt - o0); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_simultaneous();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
